// File: rtl/fib_bcd_converter_pkg.sv
// rtl/fib_bcd_converter_pkg.sv - shared state encodings, BCD constants and leading-zero helper
package fib_bcd_converter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int         BCD_DIGITS    = 4;
  localparam logic [3:0] ADJ_THRESHOLD = 4'd5;

  // Units digit is never blanked, so bit 0 is always clear.
  function automatic logic [3:0] lz_mask(input logic [15:0] bcd);
    logic l3, l2, l1;
    l3 = (bcd[15:12] == 4'd0);
    l2 = l3 & (bcd[11:8] == 4'd0);
    l1 = l2 & (bcd[7:4] == 4'd0);
    return {l3, l2, l1, 1'b0};
  endfunction

endpackage

// File: rtl/bcd_adjust_digit.sv
// rtl/bcd_adjust_digit.sv - combinational add-3 correction for one BCD digit
module bcd_adjust_digit
  import fib_bcd_converter_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  assign digit_o = (digit_i >= ADJ_THRESHOLD) ? digit_i + 4'd3 : digit_i;

endmodule

// File: rtl/fib_bcd_converter.sv
// rtl/fib_bcd_converter.sv - sequential double-dabble binary to 4-digit BCD converter
module fib_bcd_converter
  import fib_bcd_converter_pkg::*;
#(
  parameter int binwidth = 13,
  parameter int cntwidth = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [binwidth-1:0] bin,
  output logic                ready,
  output logic                done,
  output logic [3:0]          d3,
  output logic [3:0]          d2,
  output logic [3:0]          d1,
  output logic [3:0]          d0,
  output logic [3:0]          lz
);

  localparam logic [cntwidth-1:0] CNT_LOAD = cntwidth'(binwidth);
  localparam logic [cntwidth-1:0] CNT_ONE  = cntwidth'(1);

  state_e              state_q, state_d;
  logic [binwidth-1:0] shift_q, shift_d;
  logic [15:0]         acc_q, acc_d;
  logic [15:0]         acc_adj;
  logic [cntwidth-1:0] cnt_q, cnt_d;
  logic [15:0]         dig_q, dig_d;
  logic [3:0]          lz_q, lz_d;
  logic                done_q, done_d;

  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_adj
    bcd_adjust_digit u_adj (
      .digit_i (acc_q[4*g +: 4]),
      .digit_o (acc_adj[4*g +: 4])
    );
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    dig_d   = dig_q;
    lz_d    = lz_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          shift_d = bin;
          acc_d   = '0;
          cnt_d   = CNT_LOAD;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // Adjust first, then shift the whole {BCD, binary} word left by one.
        {acc_d, shift_d} = {acc_adj, shift_q} << 1;
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = DONE;
        end
      end
      DONE: begin
        dig_d   = acc_q;
        lz_d    = lz_mask(acc_q);
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      dig_q   <= '0;
      lz_q    <= 4'b1110;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      dig_q   <= dig_d;
      lz_q    <= lz_d;
      done_q  <= done_d;
    end
  end

  assign ready = (state_q == IDLE);
  assign done  = done_q;
  assign d3    = dig_q[15:12];
  assign d2    = dig_q[11:8];
  assign d1    = dig_q[7:4];
  assign d0    = dig_q[3:0];
  assign lz    = lz_q;

endmodule

// File: tb/tb_fib_bcd_converter.sv
// tb/tb_fib_bcd_converter.sv - self-checking scoreboard bench for fib_bcd_converter
module tb_fib_bcd_converter;

  localparam int BW      = 13;
  localparam int LATENCY = BW + 1;

  typedef struct {
    logic [15:0] dig;
    logic [3:0]  lz;
    int          acc_cyc;
  } exp_t;

  logic          clk, rst, start, ready, done;
  logic [BW-1:0] bin;
  logic [3:0]    d3, d2, d1, d0, lz;

  exp_t exp_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   done_cnt = 0;
  int   acc_cnt  = 0;
  int   n_issued = 0;

  fib_bcd_converter #(.binwidth(BW), .cntwidth(4)) dut (
    .clock (clk),
    .reset (rst),
    .start (start),
    .bin   (bin),
    .ready (ready),
    .done  (done),
    .d3    (d3),
    .d2    (d2),
    .d1    (d1),
    .d0    (d0),
    .lz    (lz)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic [15:0] ref_digits(input int v);
    logic [3:0] a, b, c, d;
    a = 4'((v / 1000) % 10);
    b = 4'((v / 100) % 10);
    c = 4'((v / 10) % 10);
    d = 4'(v % 10);
    return {a, b, c, d};
  endfunction

  function automatic logic [3:0] ref_lz(input int v);
    return {v < 1000, v < 100, v < 10, 1'b0};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Accepting edges push the model result; reset discards anything in flight.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      exp_q.delete();
    end else if (start && ready) begin
      exp_q.push_back('{ref_digits(int'(bin)), ref_lz(int'(bin)), cyc});
      acc_cnt++;
    end
  end

  always @(negedge clk) begin
    if (!rst && done) begin
      exp_t e;
      done_cnt++;
      check("sb_nonempty_on_done", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("digits", {16'd0, d3, d2, d1, d0}, {16'd0, e.dig});
        check("lz", {28'd0, lz}, {28'd0, e.lz});
        check("latency", 32'(cyc - e.acc_cyc), 32'(LATENCY));
      end
    end
  end

  task automatic wait_drain();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && ready) break;
    end
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_conv(input int v);
    @(negedge clk);
    bin   = BW'(v);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_issued++;
    wait_drain();
  endtask

  task automatic wait_accepts(input int target);
    for (int i = 0; i < 40; i++) begin
      if (acc_cnt >= target) break;
      @(negedge clk);
    end
    check("accept_timeout", 32'(acc_cnt >= target), 32'd1);
  endtask

  initial begin
    int base_done;
    int base_acc;
    int vals[6];
    vals = '{1, 2, 3, 5, 8, 13};
    rst   = 1'b1;
    start = 1'b0;
    bin   = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("rst_ready", 32'(ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_digits", {16'd0, d3, d2, d1, d0}, 32'd0);
    check("rst_lz", {28'd0, lz}, 32'hE);

    do_conv(0);
    do_conv(233);
    check("d233", {16'd0, d3, d2, d1, d0}, 32'h0233);
    do_conv(8191);
    check("d8191_lz", {28'd0, lz}, 32'h0);
    do_conv(5);

    // Start arriving mid-conversion must be dropped.
    base_done = done_cnt;
    @(negedge clk);
    bin   = BW'(144);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_issued++;
    repeat (4) @(negedge clk);
    bin   = BW'(89);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bin   = '0;
    wait_drain();
    repeat (20) @(negedge clk);
    check("ignore_one_done", 32'(done_cnt - base_done), 32'd1);
    check("ignore_digits", {16'd0, d3, d2, d1, d0}, 32'h0144);

    // Start held high: each done cycle should accept the next operand.
    base_done = done_cnt;
    base_acc  = acc_cnt;
    @(negedge clk);
    bin   = BW'(vals[0]);
    start = 1'b1;
    for (int i = 1; i < 6; i++) begin
      wait_accepts(base_acc + i);
      bin = BW'(vals[i]);
    end
    wait_accepts(base_acc + 6);
    start = 1'b0;
    n_issued += 6;
    wait_drain();
    check("b2b_done_count", 32'(done_cnt - base_done), 32'd6);

    // Reset mid-conversion aborts without a done pulse.
    base_done = done_cnt;
    @(negedge clk);
    bin   = BW'(610);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("abort_no_done", 32'(done_cnt - base_done), 32'd0);
    check("abort_digits", {16'd0, d3, d2, d1, d0}, 32'd0);
    check("abort_lz", {28'd0, lz}, 32'hE);
    check("abort_ready", 32'(ready), 32'd1);
    do_conv(377);

    bin = BW'(1234);
    repeat (5) @(negedge clk);
    check("hold_digits", {16'd0, d3, d2, d1, d0}, 32'h0377);
    check("hold_lz", {28'd0, lz}, 32'h8);

    for (int v = 0; v < 8192; v += 7) begin
      do_conv(v);
    end
    do_conv(8191);
    do_conv(999);
    do_conv(1000);

    repeat (5) @(negedge clk);
    check("final_sb_empty", 32'(exp_q.size()), 32'd0);
    check("final_done_count", 32'(done_cnt), 32'(n_issued));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
